// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - shared constants and types for the Gamepad Pmod receiver
package gamepad_pkg;

   localparam int NUM_BITS_DEF  = 24;
   localparam int CTRL_BITS_DEF = 12;
   localparam int TIMEOUT_W_DEF = 20;

   localparam int BTN_B      = 11;
   localparam int BTN_Y      = 10;
   localparam int BTN_SELECT = 9;
   localparam int BTN_START  = 8;
   localparam int BTN_UP     = 7;
   localparam int BTN_DOWN   = 6;
   localparam int BTN_LEFT   = 5;
   localparam int BTN_RIGHT  = 4;
   localparam int BTN_A      = 3;
   localparam int BTN_X      = 2;
   localparam int BTN_L      = 1;
   localparam int BTN_R      = 0;

   // An unplugged controller leaves its data line pulled high for every bit.
   localparam logic [11:0] ABSENT = 12'hFFF;

   typedef enum logic [1:0] {
      CMT_NONE,
      CMT_GOOD,
      CMT_ABSENT,
      CMT_ERROR
   } commit_e;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with a registered rising-edge pulse
module sync_edge_detect
(
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic sync_out,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   always_comb begin
      meta_d = pin;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign sync_out = sync_q;
   assign rise     = rise_q;

endmodule

// File: rtl/gamepad_pmod_receiver.sv
// rtl/gamepad_pmod_receiver.sv - deserialises Gamepad Pmod frames into controller-0 button state
import gamepad_pkg::*;

module gamepad_pmod_receiver
#(
   parameter int NUM_BITS  = NUM_BITS_DEF,
   parameter int CTRL_BITS = CTRL_BITS_DEF,
   parameter int TIMEOUT_W = TIMEOUT_W_DEF
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pmod_data,
   input  logic                 pmod_clk,
   input  logic                 pmod_latch,
   output logic [CTRL_BITS-1:0] buttons,
   output logic                 up,
   output logic                 down,
   output logic                 left,
   output logic                 right,
   output logic                 start,
   output logic                 present,
   output logic                 frame_valid,
   output logic                 frame_error
);

   localparam int                CNT_W    = $clog2(NUM_BITS + 2);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_BITS);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(NUM_BITS + 1);
   localparam logic [TIMEOUT_W-1:0] WDG_MAX = '1;

   logic clk_sync, clk_rise;
   logic latch_sync, latch_rise;

   sync_edge_detect u_clk_sync (
      .clk      (clk),
      .reset    (reset),
      .pin      (pmod_clk),
      .sync_out (clk_sync),
      .rise     (clk_rise)
   );

   sync_edge_detect u_latch_sync (
      .clk      (clk),
      .reset    (reset),
      .pin      (pmod_latch),
      .sync_out (latch_sync),
      .rise     (latch_rise)
   );

   logic                 data_meta_q, data_meta_d;
   logic                 data_sync_q, data_sync_d;
   logic [NUM_BITS-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [TIMEOUT_W-1:0] wdg_q, wdg_d;
   logic [CTRL_BITS-1:0] buttons_q, buttons_d;
   logic                 present_q, present_d;
   logic                 frame_valid_q, frame_valid_d;
   logic                 frame_error_q, frame_error_d;
   logic [CTRL_BITS-1:0] candidate;
   commit_e              outcome;

   assign candidate = shreg_q[NUM_BITS-1 -: CTRL_BITS];

   always_comb begin
      outcome = CMT_NONE;
      if (latch_rise) begin
         if (bitcnt_q != CNT_FULL)
            outcome = CMT_ERROR;
         else if (candidate == ABSENT)
            outcome = CMT_ABSENT;
         else
            outcome = CMT_GOOD;
      end
   end

   always_comb begin
      data_meta_d   = pmod_data;
      data_sync_d   = data_meta_q;
      shreg_d       = shreg_q;
      bitcnt_d      = bitcnt_q;
      buttons_d     = buttons_q;
      present_d     = present_q;
      frame_valid_d = 1'b0;
      frame_error_d = 1'b0;
      wdg_d         = (wdg_q == WDG_MAX) ? wdg_q : wdg_q + TIMEOUT_W'(1);

      // A silent link keeps forcing the outputs idle until a latch arrives.
      if (wdg_q == WDG_MAX) begin
         buttons_d = '0;
         present_d = 1'b0;
      end

      // Latch takes priority; a coincident shift clock is dropped.
      if (latch_rise) begin
         bitcnt_d = '0;
         wdg_d    = '0;
         case (outcome)
            CMT_GOOD: begin
               buttons_d     = candidate;
               present_d     = 1'b1;
               frame_valid_d = 1'b1;
            end
            CMT_ABSENT: begin
               buttons_d     = '0;
               present_d     = 1'b0;
               frame_valid_d = 1'b1;
            end
            default: begin
               buttons_d     = buttons_q;
               present_d     = present_q;
               frame_error_d = 1'b1;
            end
         endcase
      end else if (clk_rise) begin
         shreg_d = {shreg_q[NUM_BITS-2:0], data_sync_q};
         if (bitcnt_q != CNT_SAT)
            bitcnt_d = bitcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_meta_q   <= 1'b0;
         data_sync_q   <= 1'b0;
         shreg_q       <= '0;
         bitcnt_q      <= '0;
         wdg_q         <= '0;
         buttons_q     <= '0;
         present_q     <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         data_meta_q   <= data_meta_d;
         data_sync_q   <= data_sync_d;
         shreg_q       <= shreg_d;
         bitcnt_q      <= bitcnt_d;
         wdg_q         <= wdg_d;
         buttons_q     <= buttons_d;
         present_q     <= present_d;
         frame_valid_q <= frame_valid_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign buttons     = buttons_q;
   assign present     = present_q;
   assign frame_valid = frame_valid_q;
   assign frame_error = frame_error_q;

   assign up    = buttons_q[BTN_UP]    & present_q;
   assign down  = buttons_q[BTN_DOWN]  & present_q;
   assign left  = buttons_q[BTN_LEFT]  & present_q;
   assign right = buttons_q[BTN_RIGHT] & present_q;
   assign start = buttons_q[BTN_START] & present_q;

endmodule

// File: tb/tb_gamepad_pmod_receiver.sv
// tb/tb_gamepad_pmod_receiver.sv - directed self-checking bench for gamepad_pmod_receiver
module tb_gamepad_pmod_receiver;

   localparam int TW = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        pmod_data;
   logic        pmod_clk;
   logic        pmod_latch;
   logic [11:0] buttons;
   logic        up, down, left, right, start;
   logic        present;
   logic        frame_valid;
   logic        frame_error;

   int n_checks = 0;
   int n_fail   = 0;

   gamepad_pmod_receiver #(
      .NUM_BITS  (24),
      .CTRL_BITS (12),
      .TIMEOUT_W (TW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pmod_data   (pmod_data),
      .pmod_clk    (pmod_clk),
      .pmod_latch  (pmod_latch),
      .buttons     (buttons),
      .up          (up),
      .down        (down),
      .left        (left),
      .right       (right),
      .start       (start),
      .present     (present),
      .frame_valid (frame_valid),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pclk_bit(input logic b);
      pmod_data = b;
      cycles(4);
      pmod_clk = 1'b1;
      cycles(4);
      pmod_clk = 1'b0;
   endtask

   task automatic send(input logic [11:0] c0, input logic [11:0] c1, input int n);
      logic [23:0] w;
      w = {c0, c1};
      for (int i = 0; i < n; i++) pclk_bit((i < 24) ? w[23-i] : 1'b0);
      cycles(4);
   endtask

   // Latch pin rises just after an edge; the strobe must appear after the 4th edge.
   task automatic latch_and_check(input string tag, input logic with_clk, input logic exp_valid,
                                  input logic [11:0] exp_btn, input logic exp_present);
      pmod_latch = 1'b1;
      if (with_clk) pmod_clk = 1'b1;
      cycles(3);
      check({tag, "_early"}, {30'd0, frame_valid, frame_error}, 32'd0);
      step();
      check({tag, "_valid"}, {31'd0, frame_valid}, {31'd0, exp_valid});
      check({tag, "_error"}, {31'd0, frame_error}, {31'd0, ~exp_valid});
      check({tag, "_buttons"}, {20'd0, buttons}, {20'd0, exp_btn});
      check({tag, "_present"}, {31'd0, present}, {31'd0, exp_present});
      step();
      check({tag, "_after"}, {30'd0, frame_valid, frame_error}, 32'd0);
      pmod_latch = 1'b0;
      pmod_clk   = 1'b0;
   endtask

   initial begin
      logic seen;
      reset      = 1'b1;
      pmod_data  = 1'b0;
      pmod_clk   = 1'b0;
      pmod_latch = 1'b0;
      cycles(3);
      check("rst_buttons", {20'd0, buttons}, 32'd0);
      check("rst_flags", {25'd0, present, frame_valid, frame_error, up, down, left, right},
            32'd0);
      reset = 1'b0;
      cycles(2);

      send(12'h080, 12'hFFF, 24);
      latch_and_check("up", 1'b0, 1'b1, 12'h080, 1'b1);
      check("up_alias", {27'd0, up, down, left, right, start}, 32'b10000);

      send(12'hFFF, 12'hFFF, 24);
      latch_and_check("absent", 1'b0, 1'b1, 12'h000, 1'b0);
      check("absent_alias", {27'd0, up, down, left, right, start}, 32'd0);

      send(12'h100, 12'hFFF, 24);
      latch_and_check("start", 1'b0, 1'b1, 12'h100, 1'b1);
      check("start_alias", {31'd0, start}, 32'd1);
      send(12'h000, 12'hFFF, 23);
      latch_and_check("short", 1'b0, 1'b0, 12'h100, 1'b1);
      send(12'h000, 12'hFFF, 25);
      latch_and_check("long", 1'b0, 1'b0, 12'h100, 1'b1);

      send(12'h00C, 12'hFFF, 24);
      latch_and_check("simul", 1'b1, 1'b1, 12'h00C, 1'b1);
      send(12'h800, 12'h000, 24);
      latch_and_check("post_simul", 1'b0, 1'b1, 12'h800, 1'b1);

      send(12'h030, 12'hFFF, 24);
      latch_and_check("lr", 1'b0, 1'b1, 12'h030, 1'b1);
      check("lr_alias", {30'd0, left, right}, 32'b11);
      seen = 1'b0;
      for (int i = 0; i < (1 << TW) - 2; i++) begin
         step();
         if (frame_valid | frame_error) seen = 1'b1;
      end
      check("wdg_before_buttons", {20'd0, buttons}, 32'h030);
      check("wdg_before_present", {31'd0, present}, 32'd1);
      step();
      if (frame_valid | frame_error) seen = 1'b1;
      check("wdg_fire_buttons", {20'd0, buttons}, 32'd0);
      check("wdg_fire_present", {31'd0, present}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         step();
         if (frame_valid | frame_error) seen = 1'b1;
      end
      check("wdg_no_strobe", {31'd0, seen}, 32'd0);
      check("wdg_hold_buttons", {20'd0, buttons}, 32'd0);

      send(12'h041, 12'hFFF, 24);
      latch_and_check("restore", 1'b0, 1'b1, 12'h041, 1'b1);
      check("restore_down", {31'd0, down}, 32'd1);

      for (int i = 0; i < 10; i++) pclk_bit(1'b0);
      reset = 1'b1;
      cycles(2);
      check("midrst_buttons", {20'd0, buttons}, 32'd0);
      check("midrst_present", {31'd0, present}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 14; i++) pclk_bit(1'b0);
      cycles(4);
      latch_and_check("midrst_frame", 1'b0, 1'b0, 12'h000, 1'b0);
      send(12'h200, 12'hFFF, 24);
      latch_and_check("after_rst", 1'b0, 1'b1, 12'h200, 1'b1);

      cycles(6);
      latch_and_check("no_clocks", 1'b0, 1'b0, 12'h200, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gamepad_pmod_receiver.md
Name: gamepad_pmod_receiver

Overview:
- Receives the serial shift stream from the Gamepad Pmod (data/clk/latch pins on ui_in) and produces debounced-by-frame, registered button states for controller 0.
- Sits directly upstream of the VGA screensaver core; its up/down/left/right/start outputs drive logo steering and manual-mode toggling.
- Adds frame length checking, a frame-valid strobe, controller presence detection and a link-loss watchdog.

Parameters:
- NUM_BITS, 24, Pmod clocks per frame: 2 controllers × 12 bits. Only controller 0 is decoded.
- CTRL_BITS, 12, bits per controller.
- TIMEOUT_W, 20, watchdog counter width. Timeout fires when the counter reaches all-ones.

Ports:
- clk  input  1  system clock (pixel clock domain)
- reset  input  1  synchronous, active-high reset
- pmod_data  input  1  serial data, asynchronous to clk
- pmod_clk  input  1  Pmod shift clock, asynchronous
- pmod_latch  input  1  Pmod frame latch, asynchronous
- buttons  output  12  controller-0 state, 1 = pressed. Bit map: [11]B [10]Y [9]select [8]start [7]up [6]down [5]left [4]right [3]A [2]X [1]L [0]R
- up, down, left, right, start  output  1 each  aliases of the buttons bits, gated by present
- present  output  1  controller 0 connected
- frame_valid  output  1  one-cycle strobe when a good frame commits
- frame_error  output  1  one-cycle strobe when a frame is discarded

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset. Reset clears all sync flops, the shift register, bit counter, watchdog, buttons, present and both strobes to 0.
- Synchronisers: each pin passes through 2 FFs. pmod_clk and pmod_latch also get an edge-detect FF. A rising edge is recognised 3 clk cycles after the pin transition; data is sampled from its 2nd sync stage on that same cycle.
- Shifting: on each recognised pmod_clk rise, shreg <= {shreg[NUM_BITS-2:0], data_s}. bitcnt increments and saturates at NUM_BITS+1.
- Frame commit happens on a recognised pmod_latch rise:
  - If bitcnt == NUM_BITS: candidate = shreg[NUM_BITS-1 -: CTRL_BITS]. The first-shifted bit lands in [11].
  - If candidate == 12'hFFF, the controller is absent: present <= 0 and buttons <= 0.
  - Otherwise present <= 1 and buttons <= candidate.
  - frame_valid pulses on the cycle after edge recognition, coincident with the updated outputs.
  - If bitcnt != NUM_BITS (short or overflow frame): buttons and present hold their values and frame_error pulses.
  - In every case, bitcnt <= 0 and the watchdog <= 0.
- Simultaneous pmod_clk and pmod_latch edges recognised in the same cycle: the latch wins and the clk edge is discarded (no shift, bitcnt <= 0).
- Latch seen before any clocks (bitcnt = 0): counts as an error.
- Watchdog: increments every cycle and saturates at all-ones. On reaching all-ones: buttons <= 0 and present <= 0, with no strobe. This repeats every cycle until the next latch.
- Aliases are combinational from the registered buttons, ANDed with present. No added latency.
- Output latency from the pin edge of pmod_latch to updated buttons is 4 clk cycles.
- Reset asserted mid-frame discards the partial frame. The next frame is only accepted after a fresh latch, so the frame in progress is counted as an error.

Decomposition:
- Shared package gamepad_pkg holds:
  - button index localparams (BTN_B=11 … BTN_R=0)
  - NUM_BITS and CTRL_BITS defaults
  - the ABSENT pattern 12'hFFF
- One sub-module: sync_edge_detect (2FF synchroniser plus rising-edge pulse, reset input). Instantiated for pmod_clk and pmod_latch; pmod_data uses its synchronised output only.

Test Plan:
- Reset, then a 24-clock frame with controller-0 bits 0000_1000_0000 (up) and 12'hFFF for controller 1, then latch -> buttons=12'h080, up=1, present=1, frame_valid high exactly one cycle, 4 clk after the latch pin edge.
- Frame of 24 ones -> present=0, buttons=0, up..start=0, frame_valid pulses.
- After a good frame with start pressed (12'h100), send a 23-clock frame with 12'h000 -> frame_error pulses, buttons stays 12'h100. Then a 25-clock frame -> frame_error again.
- Drive pmod_clk and pmod_latch rising on the same clk edge after 24 clocks -> commit uses the 24 prior bits, and the next frame needs a full 24 fresh clocks.
- Good frame 12'h030 (left+right), then no latch for 2^20 cycles -> buttons=0 and present=0 at cycle 2^20-1, with no strobes. A subsequent good frame restores the state.
- Assert reset after 10 bits of a frame, release, then finish the frame and latch -> frame_error=1, outputs remain 0. The following full frame commits normally.
